saber_centroid: RTL and testbench

- Produces the per-frame saber position that feeds the trace/trail renderer.
- Accumulates the coordinates of every masked (saber-coloured) pixel during a frame.
- On the new-frame pulse it snapshots the sums and runs two sequential dividers, then presents the centroid x/y with a one-cycle valid strobe.
- Sits between the colour-threshold mask stage and the trace display's x_in/y_in/nf_in inputs.

---
 rtl/saber_pkg.sv | 10 +
 rtl/seq_divider.sv | 59 +++++
 rtl/saber_centroid.sv | 107 ++++++++++
 tb/tb_saber_centroid.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/saber_pkg.sv
// Shared constants and FSM state type for the saber centroid block.
package saber_pkg;
    localparam int MAX_H      = 1280;
    localparam int MAX_V      = 720;
    localparam int MIN_PIXELS = 16;
    localparam int SUM_W      = 32;
    localparam int CNT_W      = 20;

    typedef enum logic [1:0] {IDLE, DIVIDE, DONE} centroid_state_t;
endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, SUM_W cycles per result.
module seq_divider #(
    parameter int SUM_W = 32,
    parameter int CNT_W = 20
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [SUM_W-1:0] dividend_in,
    input  logic [CNT_W-1:0] divisor_in,
    output logic [SUM_W-1:0] quotient_out,
    output logic             done_out
);
    localparam int IW = $clog2(SUM_W);

    logic [SUM_W-1:0] quo;
    logic [CNT_W:0]   rem;
    logic [CNT_W-1:0] dvs;
    logic [IW-1:0]    iter;
    logic             running;
    logic [CNT_W:0]   rem_sh;
    logic             fits;

    // Divisor 0 simply yields all-ones; the caller never uses that result.
    always_comb begin
        rem_sh = {rem[CNT_W-1:0], quo[SUM_W-1]};
        fits   = rem_sh >= {1'b0, dvs};
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            quo      <= '0;
            rem      <= '0;
            dvs      <= '0;
            iter     <= '0;
            running  <= 1'b0;
            done_out <= 1'b0;
        end else begin
            done_out <= 1'b0;
            if (start_in) begin
                quo     <= dividend_in;
                rem     <= '0;
                dvs     <= divisor_in;
                iter    <= '0;
                running <= 1'b1;
            end else if (running) begin
                rem  <= fits ? rem_sh - {1'b0, dvs} : rem_sh;
                quo  <= {quo[SUM_W-2:0], fits};
                iter <= iter + 1'b1;
                if (iter == IW'(SUM_W - 1)) begin
                    running  <= 1'b0;
                    done_out <= 1'b1;
                end
            end
        end
    end

    assign quotient_out = quo;
endmodule

// File: rtl/saber_centroid.sv
// Per-frame centroid of masked pixels; sums snapshot on nf_in, then two sequential dividers.
module saber_centroid
    import saber_pkg::*;
#(
    parameter int MAX_H      = saber_pkg::MAX_H,
    parameter int MAX_V      = saber_pkg::MAX_V,
    parameter int MIN_PIXELS = saber_pkg::MIN_PIXELS,
    parameter int SUM_W      = saber_pkg::SUM_W,
    parameter int CNT_W      = saber_pkg::CNT_W
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        valid_in,
    input  logic        mask_in,
    input  logic        nf_in,
    output logic [11:0] x_out,
    output logic [10:0] y_out,
    output logic        found_out,
    output logic        valid_out,
    output logic        busy_out,
    output logic        dropped_out
);
    if (longint'(MAX_H) * MAX_V * MAX_H >= (longint'(1) << SUM_W) ||
        longint'(MAX_H) * MAX_V >= (longint'(1) << CNT_W)) begin : g_range_chk
        $error("saber_centroid: accumulator widths too small for the frame size");
    end

    centroid_state_t  state, state_nx;
    logic [SUM_W-1:0] sum_x, sum_y, quo_x, quo_y;
    logic [CNT_W-1:0] count, snap_count;
    logic             pix, start, done_x, done_y;
    logic             unused_quo;

    assign pix        = valid_in && mask_in;
    assign start      = nf_in && (state == IDLE);
    assign busy_out   = (state != IDLE);
    assign unused_quo = ^{quo_x[SUM_W-1:12], quo_y[SUM_W-1:11], done_y};

    // A masked pixel coincident with nf_in opens the new frame.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sum_x <= '0;
            sum_y <= '0;
            count <= '0;
        end else if (nf_in) begin
            sum_x <= pix ? SUM_W'(hcount_in) : '0;
            sum_y <= pix ? SUM_W'(vcount_in) : '0;
            count <= pix ? CNT_W'(1) : '0;
        end else if (pix) begin
            sum_x <= sum_x + SUM_W'(hcount_in);
            sum_y <= sum_y + SUM_W'(vcount_in);
            count <= count + 1'b1;
        end
    end

    // The dividers' operand registers hold the summed snapshot.
    seq_divider #(.SUM_W(SUM_W), .CNT_W(CNT_W)) u_div_x (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start),
        .dividend_in(sum_x), .divisor_in(count),
        .quotient_out(quo_x), .done_out(done_x)
    );

    seq_divider #(.SUM_W(SUM_W), .CNT_W(CNT_W)) u_div_y (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start),
        .dividend_in(sum_y), .divisor_in(count),
        .quotient_out(quo_y), .done_out(done_y)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (nf_in)  state_nx = DIVIDE;
            DIVIDE:  if (done_x) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            snap_count  <= '0;
            x_out       <= '0;
            y_out       <= '0;
            found_out   <= 1'b0;
            valid_out   <= 1'b0;
            dropped_out <= 1'b0;
        end else begin
            valid_out   <= (state == DONE);
            dropped_out <= nf_in && (state != IDLE);
            if (start) snap_count <= count;
            if (state == DONE) begin
                found_out <= (snap_count >= CNT_W'(MIN_PIXELS));
                if (snap_count >= CNT_W'(MIN_PIXELS)) begin
                    x_out <= quo_x[11:0];
                    y_out <= quo_y[10:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_saber_centroid.sv
// Scoreboard bench: stimulus pushes expected centroids, a negedge monitor checks them on valid_out.
module tb_saber_centroid;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [10:0] hcount_in = '0;
    logic [9:0]  vcount_in = '0;
    logic        valid_in = 1'b0;
    logic        mask_in = 1'b0;
    logic        nf_in = 1'b0;
    logic [11:0] x_out;
    logic [10:0] y_out;
    logic        found_out, valid_out, busy_out, dropped_out;

    saber_centroid dut (
        .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .valid_in(valid_in), .mask_in(mask_in), .nf_in(nf_in),
        .x_out(x_out), .y_out(y_out), .found_out(found_out),
        .valid_out(valid_out), .busy_out(busy_out), .dropped_out(dropped_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [11:0] x;
        logic [10:0] y;
        logic        found;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   drop_cnt = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk_in) begin
        if (dropped_out === 1'b1) drop_cnt++;
        if (valid_out !== 1'b0) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'(valid_out), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("x_out", 32'(x_out), 32'(e.x));
                chk("y_out", 32'(y_out), 32'(e.y));
                chk("found_out", 32'(found_out), 32'(e.found));
                chk("latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic pix(input int h, input int v);
        valid_in = 1'b1; mask_in = 1'b1;
        hcount_in = 11'(h); vcount_in = 10'(v);
        tick(1);
        valid_in = 1'b0; mask_in = 1'b0;
    endtask

    // Pulses nf_in (optionally with a coincident masked pixel) and queues the expected result.
    task automatic frame_end(input bit with_pix, input int h, input int v,
                             input bit push, input int ex, input int ey, input bit ef);
        nf_in = 1'b1;
        if (with_pix) begin
            valid_in = 1'b1; mask_in = 1'b1;
            hcount_in = 11'(h); vcount_in = 10'(v);
        end
        tick(1);
        nf_in = 1'b0; valid_in = 1'b0; mask_in = 1'b0;
        if (push) sb.push_back('{12'(ex), 11'(ey), ef, cyc + 34});
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick(1);
            n++;
        end
        if (sb.size() != 0) begin
            chk("result_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        tick(3);
        chk("rst_x", 32'(x_out), 32'd0);
        chk("rst_y", 32'(y_out), 32'd0);
        chk("rst_found", 32'(found_out), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_dropped", 32'(dropped_out), 32'd0);
        rst_in = 1'b0;
        tick(2);

        // 4x4 block: sum_x=1624, sum_y=824, count=16 -> (101, 51)
        for (int yy = 50; yy < 54; yy++)
            for (int xx = 100; xx < 104; xx++) pix(xx, yy);
        frame_end(0, 0, 0, 1, 101, 51, 1);
        chk("busy_after_nf", 32'(busy_out), 32'd1);
        drain();

        // 10 pixels: below threshold, coordinates hold
        for (int i = 0; i < 10; i++) pix(10 + i, 20);
        frame_end(0, 0, 0, 1, 101, 51, 0);
        drain();

        // empty frame
        frame_end(0, 0, 0, 1, 101, 51, 0);
        drain();

        // frame A at (400,200); second nf 10 cycles later is dropped
        for (int i = 0; i < 16; i++) pix(400, 200);
        frame_end(0, 0, 0, 1, 400, 200, 1);
        tick(9);
        frame_end(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) pix(600, 100);
        drain();
        chk("dropped_pulses", 32'(drop_cnt), 32'd1);

        // closes the (600,100) frame; coincident pixel opens the next one
        frame_end(1, 200, 300, 1, 600, 100, 1);
        for (int i = 0; i < 15; i++) pix(200, 300);
        drain();
        frame_end(0, 0, 0, 1, 200, 300, 1);
        drain();

        // reset 5 cycles into DIVIDE aborts the result
        for (int i = 0; i < 20; i++) pix(5, 5);
        frame_end(0, 0, 0, 0, 0, 0, 0);
        tick(4);
        chk("busy_in_divide", 32'(busy_out), 32'd1);
        rst_in = 1'b1;
        tick(1);
        rst_in = 1'b0;
        chk("abort_x", 32'(x_out), 32'd0);
        chk("abort_y", 32'(y_out), 32'd0);
        chk("abort_found", 32'(found_out), 32'd0);
        chk("abort_valid", 32'(valid_out), 32'd0);
        chk("abort_busy", 32'(busy_out), 32'd0);
        tick(40);
        chk("abort_busy_later", 32'(busy_out), 32'd0);
        chk("dropped_pulses_final", 32'(drop_cnt), 32'd1);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
